// File: rtl/param_stack_if.sv
// param_stack_if: bundle of the data and control signals between a LIFO
// stack (param_stack) and its user.
//
// Signals (master = stack user, slave = param_stack):
//   d         master->slave  data to push
//   push      master->slave  push request
//   pop       master->slave  pop request
//   flush     master->slave  discard all entries
//   err_clr   master->slave  clear sticky error flags
//   q         slave->master  registered pop data
//   q_valid   slave->master  one-cycle pulse, q updated this cycle
//   count     slave->master  occupancy 0..DEPTH
//   empty     slave->master  count == 0
//   full      slave->master  count == DEPTH
//   overflow  slave->master  sticky, push attempted while full
//   underflow slave->master  sticky, pop attempted while empty
//   err_irq   slave->master  one-cycle pulse per new error event
//
// Handshake: push/pop/flush are single-cycle requests that are always
// accepted on the clock edge where they are high (there is no ready); the
// stack never stalls. q_valid qualifies q: whenever q_valid is 1, q carries
// the result of the pop (or push+pop) of the previous edge. Requests that
// cannot be honoured are reported through overflow/underflow/err_irq.
interface param_stack_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] d;
    logic             push;
    logic             pop;
    logic             flush;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
    logic             err_irq;

    modport master (
        output d, push, pop, flush, err_clr,
        input  q, q_valid, count, empty, full, overflow, underflow, err_irq
    );

    modport slave (
        input  d, push, pop, flush, err_clr,
        output q, q_valid, count, empty, full, overflow, underflow, err_irq
    );
endinterface

// File: rtl/param_stack.sv
// param_stack: parametrised hardware LIFO for register backup and scratch
// storage. Occupancy and full/empty status, guarded overflow/underflow with
// sticky flags and an interrupt pulse, flush, and push+pop replace-top.
//
// Ports:
//   clk      rising-edge system clock
//   reset_n  synchronous active-low reset
//   bus      param_stack_if.slave (d, push, pop, flush, err_clr in;
//            q, q_valid, count, empty, full, overflow, underflow,
//            err_irq out)
//
// Priority per cycle: reset > flush > push/pop. All outputs are registered
// except empty/full, which are decoded from the count register only.
module param_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128
) (
    input logic         clk,
    input logic         reset_n,
    param_stack_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] ADR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] q_q;
    logic             q_valid_q, q_valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             irq_q, irq_d;

    logic             is_empty, is_full;
    logic [AW-1:0]    top_addr;
    logic             mem_we;
    logic [AW-1:0]    wr_addr;
    logic             q_load;
    logic             q_bypass;
    logic             ovf_ev, unf_ev;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

    // Address of the current top entry. Held at 0 while empty so the read
    // address never wraps around to DEPTH-1. When full the low AW bits of
    // count are 0, so the subtraction lands on DEPTH-1 as intended.
    assign top_addr = is_empty ? '0 : (count_q[AW-1:0] - ADR_ONE);

    always_comb begin
        count_d  = count_q;
        mem_we   = 1'b0;
        wr_addr  = count_q[AW-1:0];
        q_load   = 1'b0;
        q_bypass = 1'b0;
        ovf_ev   = 1'b0;
        unf_ev   = 1'b0;

        if (bus.flush) begin
            count_d = '0;
        end else begin
            case ({bus.push, bus.pop})
                2'b10: begin
                    if (is_full) begin
                        ovf_ev = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        count_d = count_q + CNT_ONE;
                    end
                end
                2'b01: begin
                    if (is_empty) begin
                        unf_ev = 1'b1;
                    end else begin
                        q_load  = 1'b1;
                        count_d = count_q - CNT_ONE;
                    end
                end
                2'b11: begin
                    q_load = 1'b1;
                    if (is_empty) begin
                        // Nothing stored: the pushed word goes straight out.
                        q_bypass = 1'b1;
                    end else begin
                        // Replace-top: read old top, overwrite same slot.
                        mem_we  = 1'b1;
                        wr_addr = top_addr;
                    end
                end
                default: ;
            endcase
        end

        q_valid_d = q_load;
        // A new event in the same cycle as err_clr wins.
        ovf_d = (ovf_q & ~bus.err_clr) | ovf_ev;
        unf_d = (unf_q & ~bus.err_clr) | unf_ev;
        irq_d = ovf_ev | unf_ev;
    end

    // Storage has no reset so it maps onto block RAM; the write is gated by
    // reset_n so a push coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (mem_we && reset_n) begin
            mem[wr_addr] <= bus.d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            q_valid_q <= q_valid_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            irq_q     <= irq_d;
            if (q_load) begin
                q_q <= q_bypass ? bus.d : mem[top_addr];
            end
        end
    end

    assign bus.q         = q_q;
    assign bus.q_valid   = q_valid_q;
    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.err_irq   = irq_q;
endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;
  localparam int W = 32;
  localparam int DEPTH = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  param_stack_if #(.WIDTH(W), .DEPTH(DEPTH)) bus ();

  param_stack #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- scoreboard / reference state ----------------
  logic [W-1:0] exp_q[$];     // expected pop results, in issue order
  logic [W-1:0] stk[$];       // reference stack contents, top at back
  logic [W-1:0] m_q;          // expected held value of q
  logic         m_ovf, m_unf, m_irq, m_qv;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("count", 64'(bus.count), 64'(stk.size()));
    chk("empty", 64'(bus.empty), 64'(stk.size() == 0));
    chk("full", 64'(bus.full), 64'(stk.size() == DEPTH));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("underflow", 64'(bus.underflow), 64'(m_unf));
    chk("err_irq", 64'(bus.err_irq), 64'(m_irq));
    chk("q_valid", 64'(bus.q_valid), 64'(m_qv));
    if (bus.q_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("q_spurious", 64'(bus.q_valid), 64'(0));
      end else begin
        m_q = exp_q.pop_front();
        chk("q", 64'(bus.q), 64'(m_q));
      end
    end else begin
      chk("q_hold", 64'(bus.q), 64'(m_q));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.err_clr = 1'b0; bus.d = '0;
  endtask

  // Reset for n cycles; optionally with a push held during reset.
  task automatic do_reset(input int n, input logic push_during);
    @(negedge clk);
    reset_n = 1'b0;
    bus.push = push_during;
    bus.d = 32'hBAD0_BAD0;
    repeat (n) @(posedge clk);
    #1;
    stk.delete(); exp_q.delete();
    m_q = '0; m_ovf = 0; m_unf = 0; m_irq = 0; m_qv = 0;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    drive_idle();
  endtask

  // One clock of stimulus; reference stack updated, then outputs checked.
  task automatic step(input logic p, input logic o, input logic f,
                      input logic c, input logic [W-1:0] din);
    logic ovf_ev, unf_ev;
    @(negedge clk);
    bus.push = p; bus.pop = o; bus.flush = f; bus.err_clr = c; bus.d = din;
    ovf_ev = 0; unf_ev = 0; m_qv = 0;
    if (f) begin
      stk.delete();
    end else if (p && !o) begin
      if (stk.size() == DEPTH) ovf_ev = 1;
      else stk.push_back(din);
    end else if (!p && o) begin
      if (stk.size() == 0) unf_ev = 1;
      else begin exp_q.push_back(stk.pop_back()); m_qv = 1; end
    end else if (p && o) begin
      m_qv = 1;
      if (stk.size() == 0) exp_q.push_back(din);
      else begin exp_q.push_back(stk.pop_back()); stk.push_back(din); end
    end
    m_ovf = (m_ovf && !c) || ovf_ev;
    m_unf = (m_unf && !c) || unf_ev;
    m_irq = ovf_ev || unf_ev;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(); step(0, 0, 0, 0, '0); endtask
  task automatic push_v(input logic [W-1:0] v); step(1, 0, 0, 0, v); endtask
  task automatic pop_v(); step(0, 1, 0, 0, '0); endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] last_val;
    drive_idle();

    // Reset then idle
    do_reset(2, 1'b0);
    idle();

    // LIFO order
    push_v(32'h11); push_v(32'h22); push_v(32'h33);
    pop_v(); chk("lifo_0", 64'(bus.q), 64'h33);
    pop_v(); chk("lifo_1", 64'(bus.q), 64'h22);
    pop_v(); chk("lifo_2", 64'(bus.q), 64'h11);
    chk("lifo_empty", 64'(bus.empty), 64'(1));
    idle();

    // Fill and overflow
    last_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      last_val = $urandom();
      push_v(last_val);
    end
    push_v(32'hDEAD);
    chk("ovf_irq", 64'(bus.err_irq), 64'(1));
    idle();   // irq must drop after exactly one cycle
    pop_v(); chk("ovf_pop", 64'(bus.q), 64'(last_val));
    // Push+pop while full: replace-top, no error
    push_v(32'h1234_5678);
    step(1, 1, 0, 0, 32'hCAFE);
    step(0, 0, 0, 1, '0);     // clear overflow

    // Underflow on empty
    step(0, 0, 1, 0, '0);     // flush to empty
    pop_v();
    chk("unf_flag", 64'(bus.underflow), 64'(1));
    idle();
    // Consecutive error cycles keep irq high each cycle
    pop_v(); pop_v();
    step(0, 0, 0, 1, '0);
    chk("unf_clr", 64'(bus.underflow), 64'(0));
    // err_clr together with a new event: event wins
    step(0, 1, 0, 1, '0);
    step(0, 0, 0, 1, '0);

    // Simultaneous push+pop
    push_v(32'hA); push_v(32'hB);
    step(1, 1, 0, 0, 32'hC);
    chk("pp_q", 64'(bus.q), 64'hB);
    pop_v(); chk("pp_next", 64'(bus.q), 64'hC);
    pop_v();
    step(1, 1, 0, 0, 32'h5);
    chk("pp_bypass", 64'(bus.q), 64'h5);

    // Flush priority
    for (int i = 0; i < 5; i++) push_v(32'h100 + i);
    step(1, 1, 1, 0, 32'h77);
    chk("flush_cnt", 64'(bus.count), 64'(0));
    idle();

    // Reset asserted during a push discards it
    push_v(32'h99);
    do_reset(1, 1'b1);
    idle();
    pop_v();     // must underflow: the push under reset was dropped

    // Random mixed traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45)      push_v($urandom());
      else if (r < 85) pop_v();
      else if (r < 93) step(1, 1, 0, 0, $urandom());
      else if (r < 96) step(0, 0, 1, $urandom_range(0, 1), $urandom());
      else             step(0, 0, 0, 1, '0);
    end

    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
